cv32e40p_if_fetch_ctrl: RTL and testbench

//  Parametrised IF-stage fetch controller, successor to the single-cycle fetch handshake.

---
 rtl/cv32e40p_if_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_cv32e40p_if_fetch_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_if_fetch_ctrl.sv
// IF-stage fetch controller: OBI instruction requests with credit-based flow control,
// in-order response buffering and branch flush with stale-response discard.
module cv32e40p_if_fetch_ctrl #(
  parameter int unsigned       DEPTH           = 2,
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       DATA_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR      = 'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              pc_set_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              instr_req_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  input  logic              instr_gnt_i,
  input  logic              instr_rvalid_i,
  input  logic [DATA_W-1:0] instr_rdata_i,
  output logic              fetch_valid_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  input  logic              fetch_ready_i,
  output logic              branch_req_o,
  output logic              busy_o,
  output logic              perf_imiss_o
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SUM_W  = $clog2(DEPTH + MAX_OUTSTANDING + 2) + 1;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic                redir_q, redir_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]    discard_q, discard_d;
  logic [OPTR_W-1:0]   o_wptr_q, o_rptr_q;
  logic [PTR_W-1:0]    f_wptr_q, f_rptr_q;
  logic [FCNT_W-1:0]   f_cnt_q, f_cnt_d;
  logic [ADDR_W-1:0]   o_addr_q [MAX_OUTSTANDING];
  logic [ADDR_W-1:0]   f_addr_q [DEPTH];
  logic [DATA_W-1:0]   f_data_q [DEPTH];

  logic              pending, granted, rsp, drop, push, pop, issue_ok, launch;
  logic [SUM_W-1:0]  inflight_sum, total_sum;
  logic [ADDR_W-1:0] target, next_base;

  assign pending  = (state_q == StReq);
  assign granted  = pending & instr_gnt_i;
  // A response with nothing outstanding (e.g. arriving after reset) is ignored.
  assign rsp      = instr_rvalid_i & (out_cnt_q != '0);
  assign drop     = rsp & (discard_q != '0);
  assign push     = rsp & ~drop & ~pc_set_i;
  assign pop      = fetch_ready_i & (f_cnt_q != '0);
  assign target   = branch_addr_i & ~ADDR_W'(3);

  // Credits count the request currently on the bus so a same-cycle grant cannot overflow.
  assign inflight_sum = SUM_W'(out_cnt_q) + SUM_W'(pending) - SUM_W'(rsp);
  assign total_sum    = SUM_W'(out_cnt_q) + SUM_W'(pending) + SUM_W'(f_cnt_q)
                        - SUM_W'(pop) - SUM_W'(drop);
  assign issue_ok     = req_i & ~pc_set_i & (inflight_sum < SUM_W'(MAX_OUTSTANDING))
                        & (total_sum < SUM_W'(DEPTH));
  assign launch       = issue_ok & (~pending | instr_gnt_i);

  always_comb begin
    out_cnt_d   = out_cnt_q + CNT_W'(granted) - CNT_W'(rsp);
    next_base   = (granted & ~redir_q) ? next_addr_q + ADDR_W'(4) : next_addr_q;
    next_addr_d = pc_set_i ? target : next_base;
    addr_d      = launch ? next_base : addr_q;
    state_d     = launch ? StReq : (granted ? StIdle : state_q);
    redir_d     = granted ? 1'b0 : redir_q;
    if (pc_set_i && pending && !instr_gnt_i) redir_d = 1'b1;
    // Every transaction still outstanding after a redirect belongs to the old stream.
    discard_d   = pc_set_i ? out_cnt_d
                           : discard_q - CNT_W'(drop) + CNT_W'(granted & redir_q);
    f_cnt_d     = pc_set_i ? '0 : f_cnt_q + FCNT_W'(push) - FCNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= RESET_ADDR;
      next_addr_q <= RESET_ADDR;
      redir_q     <= 1'b0;
      out_cnt_q   <= '0;
      discard_q   <= '0;
      o_wptr_q    <= '0;
      o_rptr_q    <= '0;
      f_wptr_q    <= '0;
      f_rptr_q    <= '0;
      f_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      redir_q     <= redir_d;
      out_cnt_q   <= out_cnt_d;
      discard_q   <= discard_d;
      f_cnt_q     <= f_cnt_d;
      if (granted) begin
        o_wptr_q <= (o_wptr_q == OPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : o_wptr_q + OPTR_W'(1);
      end
      if (rsp) begin
        o_rptr_q <= (o_rptr_q == OPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : o_rptr_q + OPTR_W'(1);
      end
      if (pc_set_i) begin
        f_wptr_q <= '0;
        f_rptr_q <= '0;
      end else begin
        if (push) f_wptr_q <= (f_wptr_q == PTR_W'(DEPTH - 1)) ? '0 : f_wptr_q + PTR_W'(1);
        if (pop)  f_rptr_q <= (f_rptr_q == PTR_W'(DEPTH - 1)) ? '0 : f_rptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (granted) o_addr_q[o_wptr_q] <= addr_q;
    if (push) begin
      f_addr_q[f_wptr_q] <= o_addr_q[o_rptr_q];
      f_data_q[f_wptr_q] <= instr_rdata_i;
    end
  end

  assign instr_req_o   = pending;
  assign instr_addr_o  = addr_q;
  assign fetch_valid_o = (f_cnt_q != '0);
  assign fetch_rdata_o = f_data_q[f_rptr_q];
  assign fetch_addr_o  = f_addr_q[f_rptr_q];
  assign branch_req_o  = pc_set_i;
  assign busy_o        = pending | (out_cnt_q != '0);
  assign perf_imiss_o  = (req_i & ~fetch_valid_o) | pc_set_i;

endmodule

// File: tb/tb_cv32e40p_if_fetch_ctrl.sv
// Scoreboard bench for cv32e40p_if_fetch_ctrl: expected request and response addresses are
// queued by directed stimulus and checked by a negedge monitor against an in-order memory model.
module tb_cv32e40p_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, pc_set_i = 1'b0, fetch_ready_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        instr_req_o, instr_gnt_i, fetch_valid_o, branch_req_o, busy_o, perf_imiss_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic [31:0] instr_addr_o, fetch_rdata_o, fetch_addr_o;
  logic        gnt_en = 1'b1, rsp_en = 1'b1;

  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_req_q[$], exp_rsp_q[$], mem_q[$];

  cv32e40p_if_fetch_ctrl dut (
    .clk(clk), .rst(rst), .req_i(req_i), .pc_set_i(pc_set_i), .branch_addr_i(branch_addr_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o), .fetch_addr_o(fetch_addr_o),
    .fetch_ready_i(fetch_ready_i), .branch_req_o(branch_req_o), .busy_o(busy_o),
    .perf_imiss_o(perf_imiss_o)
  );

  always #5 clk = ~clk;
  assign instr_gnt_i = gnt_en & instr_req_o;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  // Memory responds in order, one cycle after the grant at the earliest.
  always @(posedge clk) begin
    if (rsp_en && mem_q.size() > 0) begin
      instr_rvalid_i <= 1'b1;
      instr_rdata_i  <= word_of(mem_q.pop_front());
    end else begin
      instr_rvalid_i <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && instr_req_o && instr_gnt_i) begin
      mem_q.push_back(instr_addr_o);
      if (exp_req_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL req_unexpected: got addr %h, required no request", instr_addr_o);
      end else check("req_addr", instr_addr_o, exp_req_q.pop_front());
    end
    if (!rst && fetch_valid_o && fetch_ready_i) begin
      if (exp_rsp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rsp_unexpected: got addr %h, required no response", fetch_addr_o);
      end else begin
        logic [31:0] a;
        a = exp_rsp_q.pop_front();
        check("rsp_addr", fetch_addr_o, a);
        check("rsp_data", fetch_rdata_o, word_of(a));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Raise req_i until n grants are seen, dropping it in the cycle of the last grant.
  task automatic run_fetch(input int n);
    int got = 0;
    req_i = 1'b1;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (instr_req_o && instr_gnt_i) begin
        got++;
        if (got == n) req_i = 1'b0;
      end
    end
    req_i = 1'b0;
    check("run_fetch_grants", got, n);
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_rsp_q.size() != 0 || busy_o || fetch_valid_o) && c < 200) begin
      tick(); c++;
    end
    if (c >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d responses pending, required 0", exp_rsp_q.size());
    end
  endtask

  task automatic redirect(input logic [31:0] a);
    pc_set_i = 1'b1; branch_addr_i = a;
    @(negedge clk);
    check("branch_req", branch_req_o, 1'b1);
    check("perf_imiss_branch", perf_imiss_o, 1'b1);
    tick();
    pc_set_i = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_instr_req", instr_req_o, 1'b0);
    check("rst_fetch_valid", fetch_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rst = 1'b0;

    // 1: streaming from reset address, 1-cycle rvalid -> fetch_valid latency
    fetch_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_req_q.push_back(32'h80 + 32'(4 * i));
      exp_rsp_q.push_back(32'h80 + 32'(4 * i));
    end
    fork
      run_fetch(4);
      begin
        int c = 0;
        do begin @(negedge clk); c++; end while (!instr_rvalid_i && c < 50);
        check("lat_valid_at_rvalid", fetch_valid_o, 1'b0);
        @(negedge clk);
        check("lat_valid_after_rvalid", fetch_valid_o, 1'b1);
      end
    join
    tick();
    drain();

    // 2: consumer stalled -> DEPTH words buffered, nothing in flight, resume after one pop
    fetch_ready_i = 1'b0;
    exp_req_q.push_back(32'h90); exp_req_q.push_back(32'h94); exp_req_q.push_back(32'h98);
    exp_rsp_q.push_back(32'h90); exp_rsp_q.push_back(32'h94); exp_rsp_q.push_back(32'h98);
    req_i = 1'b1;
    repeat (10) tick();
    check("stall_instr_req", instr_req_o, 1'b0);
    check("stall_busy", busy_o, 1'b0);
    check("stall_valid", fetch_valid_o, 1'b1);
    check("stall_head_addr", fetch_addr_o, 32'h90);
    check("stall_imiss", perf_imiss_o, 1'b0);
    fetch_ready_i = 1'b1;
    tick();
    fetch_ready_i = 1'b0;
    run_fetch(1);
    repeat (3) tick();
    check("resume_valid", fetch_valid_o, 1'b1);
    fetch_ready_i = 1'b1;
    drain();

    // 3a: two in flight, redirect to 0x1002 -> both dropped, next fetch 0x1000
    rsp_en = 1'b0;
    exp_req_q.push_back(32'h9C); exp_req_q.push_back(32'hA0);
    run_fetch(2);
    tick();
    redirect(32'h1002);
    @(negedge clk);
    check("flush_valid_t1", fetch_valid_o, 1'b0);
    check("flush_busy_t1", busy_o, 1'b1);
    tick();
    rsp_en = 1'b1;
    exp_req_q.push_back(32'h1000); exp_rsp_q.push_back(32'h1000);
    run_fetch(1);
    drain();

    // 3b: one word buffered, one in flight, redirect -> FIFO flushed, late word dropped
    fetch_ready_i = 1'b0;
    exp_req_q.push_back(32'h1004);
    run_fetch(1);
    repeat (3) tick();
    check("pre_flush_valid", fetch_valid_o, 1'b1);
    rsp_en = 1'b0;
    exp_req_q.push_back(32'h1008);
    run_fetch(1);
    tick();
    redirect(32'h2000);
    @(negedge clk);
    check("flush_fifo_valid", fetch_valid_o, 1'b0);
    tick();
    fetch_ready_i = 1'b1; rsp_en = 1'b1;
    exp_req_q.push_back(32'h2000); exp_rsp_q.push_back(32'h2000);
    run_fetch(1);
    drain();

    // 4: redirect while a request waits for grant -> address held, response dropped
    gnt_en = 1'b0;
    exp_req_q.push_back(32'h2004);
    req_i = 1'b1;
    for (int c = 0; c < 20 && !instr_req_o; c++) tick();
    tick();
    req_i = 1'b0;
    redirect(32'h3000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_req", instr_req_o, 1'b1);
      check("hold_addr", instr_addr_o, 32'h2004);
      tick();
    end
    gnt_en = 1'b1;
    tick();
    exp_req_q.push_back(32'h3000); exp_rsp_q.push_back(32'h3000);
    run_fetch(1);
    drain();

    // 5: address wrap past 0xFFFF_FFFC; low branch bits ignored
    redirect(32'hFFFF_FFFE);
    exp_req_q.push_back(32'hFFFF_FFFC); exp_rsp_q.push_back(32'hFFFF_FFFC);
    exp_req_q.push_back(32'h0000_0000); exp_rsp_q.push_back(32'h0000_0000);
    run_fetch(2);
    drain();

    // 6: reset with two in flight (and a branch pending) -> reset state, late rvalids ignored
    rsp_en = 1'b0; fetch_ready_i = 1'b0;
    exp_req_q.push_back(32'h4); exp_req_q.push_back(32'h8);
    run_fetch(2);
    tick();
    rst = 1'b1; pc_set_i = 1'b1; branch_addr_i = 32'h5000; req_i = 1'b1;
    tick();
    @(negedge clk);
    check("rst6_instr_req", instr_req_o, 1'b0);
    check("rst6_fetch_valid", fetch_valid_o, 1'b0);
    check("rst6_busy", busy_o, 1'b0);
    tick();
    rst = 1'b0; pc_set_i = 1'b0; req_i = 1'b0; rsp_en = 1'b1;
    repeat (4) tick();
    check("late_rvalid_valid", fetch_valid_o, 1'b0);
    check("late_rvalid_busy", busy_o, 1'b0);
    fetch_ready_i = 1'b1;
    exp_req_q.push_back(32'h80); exp_rsp_q.push_back(32'h80);
    run_fetch(1);
    drain();

    check("exp_req_left", exp_req_q.size(), 0);
    check("exp_rsp_left", exp_rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
